// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter fed by a small TX FIFO. irq pulses once the
// last queued byte has fully left the line (raises trap TRAP_CODE_UART0TX, 17).
module uart_tx #(
    parameter int unsigned CLK_FREQ   = 32'd10_000_000,
    parameter int unsigned BAUD       = 32'd9600,
    parameter int unsigned FIFO_DEPTH = 32'd8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [7:0]                      wr_data,
    input  logic                            ovf_clr,
    output logic                            tx,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            busy,
    output logic                            ovf,
    output logic                            irq
);

    localparam int unsigned DIV    = CLK_FREQ / BAUD;
    localparam int unsigned BAUD_W = (DIV > 32'd1) ? $clog2(DIV) : 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 32'd1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(DIV - 1);

    if (FIFO_DEPTH == 0) begin : g_bad_depth
        $error("uart_tx: FIFO_DEPTH must be non-zero");
    end
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              irq_q, irq_d;
    logic              busy_q, busy_d;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              drop;
    logic [7:0]        head;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];

    // A pop on the same edge frees a slot, so a write into a full FIFO is kept.
    always_comb begin : p_fifo
        push     = wr_en && (!fifo_full || pop);
        drop     = wr_en && fifo_full && !pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        ovf_d   = drop || (ovf_q && !ovf_clr);
        full_d  = (count_d == CNT_W'(FIFO_DEPTH));
        empty_d = (count_d == '0);
    end

    always_comb begin : p_fsm
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        irq_d   = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    baud_d  = BAUD_LOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_q == '0) begin
                    tx_d    = shift_q[0];
                    bit_d   = 3'd0;
                    baud_d  = BAUD_LOAD;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_LOAD;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        tx_d    = shift_q[1];
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_q == '0) begin
                    // A write arriving on this very edge bypasses the FIFO.
                    if (!fifo_empty || wr_en) begin
                        pop     = 1'b1;
                        shift_d = fifo_empty ? wr_data : head;
                        tx_d    = 1'b0;
                        baud_d  = BAUD_LOAD;
                        state_d = ST_START;
                    end else begin
                        irq_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            irq_q    <= 1'b0;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            irq_q    <= irq_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin : p_mem
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign tx    = tx_q;
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;
    assign busy  = busy_q;
    assign ovf   = ovf_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a transaction-level model predicts FIFO status
// and the byte order on the line; a monitor decodes serial frames and compares.
module tb_uart_tx;

    localparam int CLK_FREQ = 100;
    localparam int BAUD     = 10;
    localparam int DEPTH    = 4;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int FRAME    = 10 * DIV;
    localparam int CNT_W    = $clog2(DEPTH + 1);

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b1;
    logic             wr_en   = 1'b0;
    logic [7:0]       wr_data = 8'h00;
    logic             ovf_clr = 1'b0;
    logic             tx;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             ovf;
    logic             irq;

    uart_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .ovf_clr(ovf_clr),
        .tx     (tx),
        .full   (full),
        .empty  (empty),
        .count  (count),
        .busy   (busy),
        .ovf    (ovf),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes waiting in the FIFO, bytes due on the line, and
    // how many edges remain until the current frame's stop bit completes.
    logic [7:0] mq[$];
    logic [7:0] sb_q[$];
    bit         m_busy = 1'b0;
    int         m_left = 0;
    bit         m_ovf  = 1'b0;
    bit         mon_in_frame = 1'b0;

    initial begin : model
        bit do_pop;
        bit do_irq;
        bit was_full;
        bit wr;
        logic [7:0] b;
        forever begin
            @(posedge clk);
            do_pop = 1'b0;
            do_irq = 1'b0;
            if (!rst_n) begin
                mq.delete();
                sb_q.delete();
                m_busy = 1'b0;
                m_left = 0;
                m_ovf  = 1'b0;
            end else begin
                wr = wr_en;
                if (!m_busy) begin
                    do_pop = (mq.size() > 0);
                end else if (m_left == 0) begin
                    if (mq.size() > 0 || wr) begin
                        do_pop = 1'b1;
                    end else begin
                        do_irq = 1'b1;
                        m_busy = 1'b0;
                    end
                end else begin
                    m_left--;
                end
                was_full = (mq.size() == DEPTH);
                if (wr && (!was_full || do_pop)) begin
                    mq.push_back(wr_data);
                end
                if (wr && was_full && !do_pop) begin
                    m_ovf = 1'b1;
                end else if (ovf_clr) begin
                    m_ovf = 1'b0;
                end
                if (do_pop) begin
                    b = mq.pop_front();
                    sb_q.push_back(b);
                    m_busy = 1'b1;
                    m_left = FRAME - 1;
                end
            end
            #1;
            check("count", int'(count), mq.size());
            check("full", int'(full), int'(mq.size() == DEPTH));
            check("empty", int'(empty), int'(mq.size() == 0));
            check("ovf", int'(ovf), int'(m_ovf));
            check("busy", int'(busy), int'(m_busy));
            check("irq", int'(irq), int'(do_irq));
            if (do_pop) begin
                check("tx_start_edge", int'(tx), 0);
            end else if (!m_busy) begin
                check("tx_idle", int'(tx), 1);
            end
        end
    end

    // Monitor: decode each frame from the line and compare against the scoreboard.
    initial begin : monitor
        int cyc;
        int slot;
        bit frame_ok;
        logic exp_bit;
        logic [7:0] exp_b;
        logic [7:0] got_b;
        cyc = 0;
        frame_ok = 1'b1;
        exp_b = 8'h00;
        got_b = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_in_frame = 1'b0;
                continue;
            end
            if (!mon_in_frame && tx == 1'b0) begin
                check("frame_expected", int'(sb_q.size() > 0), 1);
                exp_b = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
                mon_in_frame = 1'b1;
                cyc = 0;
                frame_ok = 1'b1;
                got_b = 8'h00;
            end
            if (mon_in_frame) begin
                slot = cyc / DIV;
                if (slot == 0) exp_bit = 1'b0;
                else if (slot == 9) exp_bit = 1'b1;
                else exp_bit = exp_b[slot-1];
                if (tx !== exp_bit) frame_ok = 1'b0;
                if (slot >= 1 && slot <= 8 && (cyc % DIV) == DIV / 2) got_b[slot-1] = tx;
                cyc++;
                if (cyc == FRAME) begin
                    mon_in_frame = 1'b0;
                    check("frame_byte", int'(got_b), int'(exp_b));
                    check("frame_shape", int'(frame_ok), 1);
                end
            end
        end
    end

    task automatic write(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((m_busy || mq.size() != 0 || mon_in_frame) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", int'(n < budget), 1);
        repeat (3) @(negedge clk);
    endtask

    // Returns on the negedge just before the edge that completes a stop bit.
    task automatic wait_stop_end(input int budget);
        int n;
        n = 0;
        while (!(m_busy && m_left == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("stop_end_timeout", int'(n < budget), 1);
    endtask

    initial begin : stim
        int n;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx", int'(tx), 1);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(count), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_irq", int'(irq), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frames, including the 0xA5 pattern.
        write(8'hA5);
        wait_idle(2 * FRAME);
        for (int i = 0; i < 2; i++) begin
            write(8'($urandom));
            wait_idle(2 * FRAME);
        end

        // Back-to-back writes produce contiguous frames and a single irq.
        write(8'h01);
        write(8'h02);
        write(8'h03);
        wait_idle(4 * FRAME);

        // Fill while transmitting, overflow, clear, then write on the pop edge.
        write(8'h10);
        for (int i = 1; i <= 4; i++) write(8'(8'h10 + i));
        write(8'h15);
        check("drop_ovf", int'(ovf), 1);
        check("drop_count", int'(count), DEPTH);
        ovf_clr = 1'b1;
        write(8'h16);
        ovf_clr = 1'b0;
        check("ovf_set_wins", int'(ovf), 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared", int'(ovf), 0);
        wait_stop_end(2 * FRAME);
        write(8'h3C);
        check("full_pop_count", int'(count), DEPTH);
        check("full_pop_ovf", int'(ovf), 0);
        wait_idle(7 * FRAME);

        // Write on the final stop cycle chains the next frame without irq.
        write(8'h11);
        wait_stop_end(2 * FRAME);
        write(8'h55);
        wait_idle(3 * FRAME);

        // Reset during data bit 3 with two bytes still queued.
        write(8'hC3);
        write(8'h5A);
        write(8'h96);
        n = 0;
        while (!(m_busy && m_left == FRAME - 1 - 45) && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("bit3_timeout", int'(n < 2 * FRAME), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", int'(tx), 1);
        check("midrst_empty", int'(empty), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_count", int'(count), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * FRAME) @(negedge clk);
        check("postrst_tx", int'(tx), 1);

        // Random traffic at varying write rates.
        for (int ep = 0; ep < 15; ep++) begin
            int rate;
            rate = (ep % 3 == 0) ? 3 : ((ep % 3 == 1) ? 30 : 150);
            for (int c = 0; c < 200; c++) begin
                wr_en   = ($urandom_range(rate - 1, 0) == 0);
                wr_data = 8'($urandom);
                ovf_clr = ($urandom_range(99, 0) == 0);
                @(negedge clk);
            end
        end
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        wait_idle(7 * FRAME);

        check("sb_drained", sb_q.size(), 0);
        check("monitor_idle", int'(mon_in_frame), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default lexington::DEFAULT_CLK_FREQ (10_000_000): core clock frequency in Hz.
REQ-002 Parameter BAUD, default lexington::DEFAULT_UART_BAUD (9600): line rate in bits/s.
REQ-003 Parameter FIFO_DEPTH, default lexington::DEFAULT_UART_FIFO_DEPTH (8): TX FIFO entries; 0 is invalid, and elaboration SHALL fail on 0.
REQ-004 clk  input  1: single core clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 wr_en  input  1: push request from the UART0 register block.
REQ-007 wr_data  input  8: byte to push.
REQ-008 ovf_clr  input  1: clears the sticky overflow flag.
REQ-009 tx  output  1: serial line; idle level is 1.
REQ-010 full  output  1: FIFO holds FIFO_DEPTH entries.
REQ-011 empty  output  1: FIFO holds 0 entries.
REQ-012 count  output  $clog2(FIFO_DEPTH+1): current FIFO occupancy.
REQ-013 busy  output  1: FSM is not in IDLE.
REQ-014 ovf  output  1: sticky flag for a dropped write.
REQ-015 irq  output  1: one-cycle pulse that raises trap TRAP_CODE_UART0TX (17).

Function
REQ-016 Bit period DIV SHALL equal CLK_FREQ/BAUD with integer truncation (default 1041 cycles); elaboration SHALL fail if DIV < 2.
REQ-017 Frame format SHALL be 8N1: start bit 0, data[0] through data[7] (LSB first), stop bit 1; each bit lasts exactly DIV cycles, so a frame lasts 10*DIV cycles.
REQ-018 FIFO behaviour SHALL be first-in first-out with wrapping read/write pointers and an occupancy counter.
REQ-019 wr_en=1 with full=0 SHALL store wr_data and increment count at that edge.
REQ-020 wr_en=1 with full=1 and no pop in the same cycle SHALL drop the byte and set ovf; contents and count are unchanged.
REQ-021 wr_en=1 with full=1 and a pop in the same cycle SHALL accept the byte; count stays at FIFO_DEPTH and ovf is unchanged.
REQ-022 Simultaneous push and pop at any occupancy SHALL leave count unchanged.
REQ-023 ovf_clr=1 SHALL clear ovf; if a drop occurs in the same cycle, ovf SHALL be set (set wins).
REQ-024 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-025 IDLE: tx=1. If empty=0, pop the head byte into the shift register, load the baud counter, enter START.
REQ-026 START: tx=0 for DIV cycles, then enter DATA with bit index 0.
REQ-027 DATA: tx=shift[0] for DIV cycles per bit; shift right after each bit; after bit index 7 completes, enter STOP.
REQ-028 STOP: tx=1 for DIV cycles; at the end of STOP, pop and enter START directly if empty=0 (no idle gap between frames); otherwise enter IDLE.
REQ-029 Latency: a byte written into an empty FIFO with the FSM in IDLE at edge k SHALL drive tx low from edge k+1.
REQ-030 tx SHALL be driven from a flop (glitch-free).
REQ-031 irq SHALL pulse for exactly one cycle on the edge where STOP completes and the FIFO is empty (last queued byte fully sent).
REQ-032 irq SHALL NOT pulse between back-to-back frames.
REQ-033 A write accepted during the final STOP cycle SHALL be popped in that same cycle, suppress irq, and start the next frame with no gap.
REQ-034 busy SHALL be 1 in START, DATA and STOP.
REQ-035 Bytes already popped SHALL transmit to completion regardless of later FIFO activity.

Reset
REQ-036 On rst_n=0, asynchronously: FSM=IDLE, tx=1, FIFO pointers and count=0, empty=1, full=0, busy=0, ovf=0, irq=0, baud counter and bit index=0.
REQ-037 Reset asserted mid-frame SHALL abort the frame, return tx to 1, and discard all queued bytes.
REQ-038 The first clock edge after rst_n deasserts SHALL behave as a normal IDLE cycle.

Verification (bench parameters CLK_FREQ=100, BAUD=10, hence DIV=10; FIFO_DEPTH=4)
REQ-039 Write 0xA5 at edge 0 -> tx low edges 1-10, then data bits 1,0,1,0,0,1,0,1 for 10 cycles each, tx high edges 91-100, one irq pulse at edge 101, busy=0 afterwards.
REQ-040 Write 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous 100-cycle frames with no idle gap, exactly one irq after the third frame, count sequence 1,1,2, then decrements at each frame start.
REQ-041 With the FSM stalled mid-frame, fill the FIFO (count=4), then write 0xFF -> byte dropped, ovf=1, count=4; pulse ovf_clr -> ovf=0.
REQ-042 With full=1, write on the exact cycle the FSM pops -> write accepted, count stays 4, ovf stays 0, byte appears last in serial order.
REQ-043 Assert rst_n=0 during data bit 3 of a frame with 2 bytes queued -> tx=1, empty=1, busy=0 immediately; no irq; no further frames after release.
REQ-044 Write 0x55 exactly on the final STOP cycle of the previous frame -> no irq, next start bit begins on the following edge.
